inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 24 ++
 rtl/inst_fetch.sv | 145 ++++++++++++++
 tb/tb_inst_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-side and memory-side signals of the instruction fetch unit.
// slave is the fetch unit; master is whoever drives pc/flush and memory.
interface inst_fetch_if;
    logic [63:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_comp;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output pc, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  inst, inst_valid, inst_comp, mem_req, mem_addr
    );

    modport slave (
        input  pc, flush, mem_gnt, mem_rvalid, mem_rdata,
        output inst, inst_valid, inst_comp, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Two-entry fetch buffer with RVC support and a single outstanding
// 64-bit memory read; 32-bit instructions may straddle two words.
module inst_fetch (
    input logic         clk,
    input logic         rst_n,
    inst_fetch_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_GNT = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    logic [1:0]  state;
    logic        drop;
    logic [63:0] addr_q;

    logic        vld0;
    logic        vld1;
    logic [60:0] tag0;
    logic [60:0] tag1;
    logic [63:0] data0;
    logic [63:0] data1;

    logic [60:0] w;
    logic [60:0] w1;
    logic [1:0]  h;
    logic        lo0;
    logic        lo1;
    logic        hi0;
    logic        hi1;
    logic        lo_hit;
    logic        hi_hit;
    logic [63:0] lo_data;
    logic [63:0] hi_data;
    logic [31:0] cat32;
    logic        comp;
    logic        straddle;
    logic        valid;
    logic        vic1;
    logic        wr;
    logic        unused_ok;

    assign w  = bus.pc[63:3];
    assign w1 = w + 61'd1;
    assign h  = bus.pc[2:1];

    assign lo0 = vld0 && (tag0 == w);
    assign lo1 = vld1 && (tag1 == w);
    assign hi0 = vld0 && (tag0 == w1);
    assign hi1 = vld1 && (tag1 == w1);

    assign lo_hit  = lo0 || lo1;
    assign hi_hit  = hi0 || hi1;
    assign lo_data = lo0 ? data0 : data1;
    assign hi_data = hi0 ? data0 : data1;

    // Gather the 32 bits starting at halfword h, borrowing from W+1 at h=3.
    always_comb begin
        cat32 = 32'd0;
        unique case (h)
            2'd0:    cat32 = lo_data[31:0];
            2'd1:    cat32 = lo_data[47:16];
            2'd2:    cat32 = lo_data[63:32];
            default: cat32 = {hi_data[15:0], lo_data[63:48]};
        endcase
    end

    assign comp     = (cat32[1:0] != 2'b11);
    assign straddle = (h == 2'd3) && !comp;
    assign valid    = lo_hit && (!straddle || hi_hit);

    assign bus.inst_valid = valid;
    assign bus.inst_comp  = valid && comp;
    assign bus.inst       = !valid ? 32'd0 :
                            comp   ? {16'd0, cat32[15:0]} : cat32;

    assign bus.mem_req  = (state == WAIT_GNT);
    assign bus.mem_addr = addr_q;

    // Refill goes to an entry not holding the current word, E0 first.
    assign vic1 = vld0 && (tag0 == w);
    assign wr   = (state == WAIT_RSP) && bus.mem_rvalid &&
                  !drop && !bus.flush;

    assign unused_ok = ^{bus.pc[0], hi_data[63:16]};

    // Request sequencer; a flushed request is still completed, then dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            drop   <= 1'b0;
            addr_q <= 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.flush && !lo_hit) begin
                        addr_q <= {w, 3'b000};
                        state  <= WAIT_GNT;
                    end else if (!bus.flush && straddle && !hi_hit) begin
                        addr_q <= {w1, 3'b000};
                        state  <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (bus.flush) drop <= 1'b1;
                    if (bus.mem_gnt) state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (bus.flush) drop <= 1'b1;
                    if (bus.mem_rvalid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer entries: flush invalidates both, a live response fills the victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0  <= 1'b0;
            vld1  <= 1'b0;
            tag0  <= 61'd0;
            tag1  <= 61'd0;
            data0 <= 64'd0;
            data1 <= 64'd0;
        end else if (bus.flush) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
        end else if (wr) begin
            if (vic1) begin
                vld1  <= 1'b1;
                tag1  <= addr_q[63:3];
                data1 <= bus.mem_rdata;
            end else begin
                vld0  <= 1'b1;
                tag0  <= addr_q[63:3];
                data0 <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random
// pc/flush traffic against a byte-addressed memory image.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] img [logic [60:0]];

    int          gnt_wait = 0;
    int          rsp_wait = 1;
    int          rs = 0;
    int          cnt = 0;
    logic [63:0] cap = 64'd0;
    bit          mem_clr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [60:0] wd);
        logic [31:0] a;
        if (img.exists(wd)) return img[wd];
        a = wd[31:0] ^ {3'b000, wd[60:32]};
        return {(a * 32'h9E3779B1) ^ 32'h5BD1E995,
                (a + 32'h7F4A7C15) * 32'h85EBCA6B};
    endfunction

    function automatic logic [15:0] hw_at(input logic [63:0] a);
        logic [63:0] d;
        d = mem_word(a[63:3]);
        return d[{a[2:1], 4'b0000} +: 16];
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] p);
        logic [63:0] a;
        logic [15:0] lo;
        a  = {p[63:1], 1'b0};
        lo = hw_at(a);
        if (lo[1:0] != 2'b11) return {16'd0, lo};
        return {hw_at(a + 64'd2), lo};
    endfunction

    function automatic logic exp_comp(input logic [63:0] p);
        logic [15:0] lo;
        lo = hw_at({p[63:1], 1'b0});
        return lo[1:0] != 2'b11;
    endfunction

    // Memory model: grant after gnt_wait stall cycles, data rsp_wait later.
    always begin
        @(posedge clk);
        #2;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (mem_clr) begin
            rs = 0;
            mem_clr = 1'b0;
        end else if (rs == 2) begin
            cnt--;
            if (cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = mem_word(cap[63:3]);
                rs = 0;
            end
        end else begin
            if (rs == 0 && bus.mem_req) begin
                rs = 1;
                cnt = gnt_wait;
            end
            if (rs == 1) begin
                if (cnt == 0) begin
                    bus.mem_gnt = 1'b1;
                    cap = bus.mem_addr;
                    cnt = rsp_wait;
                    rs = 2;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bus.flush = 1'b1;
        mem_clr = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            smp();
            if (bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rvalid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            smp();
            if (bus.mem_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            smp();
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fetch_ok(input string tag, input logic [63:0] p);
        bit ok;
        wait_valid(40, ok);
        chk({tag, "_tmo"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({tag, "_inst"}, 64'(bus.inst), 64'(exp_inst(p)));
            chk({tag, "_comp"}, 64'(bus.inst_comp), 64'(exp_comp(p)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [63:0] p;
        logic [63:0] base;
        logic [31:0] held;

        bus.pc = 64'd0;
        bus.flush = 1'b1;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 64'd0;

        // reset values
        do_reset();
        rst_n = 1'b0;
        smp();
        chk("rst_req", 64'(bus.mem_req), 64'd0);
        chk("rst_addr", bus.mem_addr, 64'd0);
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_comp", 64'(bus.inst_comp), 64'd0);

        // cold miss, exact latency
        do_reset();
        img.delete();
        img[61'h200] = 64'h00000013_00000013;
        gnt_wait = 0;
        rsp_wait = 1;
        tick();
        bus.pc = 64'h1000;
        bus.flush = 1'b0;
        smp();
        chk("cold_v0", 64'(bus.inst_valid), 64'd0);
        chk("cold_req0", 64'(bus.mem_req), 64'd0);
        tick();
        smp();
        chk("cold_req1", 64'(bus.mem_req), 64'd1);
        chk("cold_addr", bus.mem_addr, 64'h1000);
        tick();
        smp();
        chk("cold_v2", 64'(bus.inst_valid), 64'd0);
        tick();
        smp();
        chk("cold_v3", 64'(bus.inst_valid), 64'd1);
        chk("cold_inst", 64'(bus.inst), 64'h13);
        chk("cold_comp", 64'(bus.inst_comp), 64'd0);

        // compressed hit, then straddle into the next word
        do_reset();
        img[61'h200] = 64'h0513_0000_4501_0013;
        img[61'h201] = 64'h1234_5678_9ABC_0000;
        tick();
        bus.pc = 64'h1000;
        bus.flush = 1'b0;
        fetch_ok("w0", 64'h1000);
        chk("w0_inst32", 64'(bus.inst), 64'h4501_0013);
        tick();
        bus.pc = 64'h1002;
        smp();
        chk("rvc_valid", 64'(bus.inst_valid), 64'd1);
        chk("rvc_inst", 64'(bus.inst), 64'h4501);
        chk("rvc_comp", 64'(bus.inst_comp), 64'd1);
        chk("rvc_noreq", 64'(bus.mem_req), 64'd0);
        tick();
        smp();
        chk("rvc_noreq2", 64'(bus.mem_req), 64'd0);
        chk("rvc_stable", 64'(bus.inst), 64'h4501);
        tick();
        bus.pc = 64'h1006;
        smp();
        chk("strad_v0", 64'(bus.inst_valid), 64'd0);
        tick();
        smp();
        chk("strad_req", 64'(bus.mem_req), 64'd1);
        chk("strad_addr", bus.mem_addr, 64'h1008);
        fetch_ok("strad", 64'h1006);
        chk("strad_inst", 64'(bus.inst), 64'h0513);
        tick();
        bus.pc = 64'h1000;
        smp();
        chk("keep_w0", 64'(bus.inst_valid), 64'd1);
        chk("keep_inst", 64'(bus.inst), 64'h4501_0013);
        tick();
        bus.pc = 64'h1008;
        smp();
        chk("keep_w1", 64'(bus.inst_valid), 64'd1);
        chk("keep_w1c", 64'(bus.inst_comp), 64'd1);

        // grant stall
        do_reset();
        img.delete();
        gnt_wait = 5;
        rsp_wait = 1;
        tick();
        bus.pc = 64'h3000;
        bus.flush = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("stall_req", 64'(bus.mem_req), 64'd1);
            chk("stall_addr", bus.mem_addr, 64'h3000);
            chk("stall_valid", 64'(bus.inst_valid), 64'd0);
            tick();
        end
        fetch_ok("stall", 64'h3000);

        // flush while waiting for data, redirect elsewhere
        gnt_wait = 0;
        rsp_wait = 3;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            p = (v == 0) ? 64'h2000 : 64'h1000;
            tick();
            bus.pc = 64'h1000;
            bus.flush = 1'b0;
            tick();
            tick();
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            bus.pc = p;
            wait_rvalid(10, ok);
            chk("drop_rsp", 64'(ok), 64'd1);
            tick();
            smp();
            chk("drop_valid", 64'(bus.inst_valid), 64'd0);
            wait_req(10, ok);
            chk("drop_req", 64'(ok), 64'd1);
            chk("drop_addr", bus.mem_addr, p);
            fetch_ok("drop", p);
        end

        // reset while waiting for data; the late response must be ignored
        do_reset();
        gnt_wait = 0;
        rsp_wait = 4;
        tick();
        bus.pc = 64'h1000;
        bus.flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_req", 64'(bus.mem_req), 64'd0);
        chk("ar_addr", bus.mem_addr, 64'd0);
        chk("ar_valid", 64'(bus.inst_valid), 64'd0);
        chk("ar_inst", 64'(bus.inst), 64'd0);
        tick();
        rst_n = 1'b1;
        wait_rvalid(10, ok);
        chk("ar_late", 64'(ok), 64'd1);
        tick();
        smp();
        chk("ar_nowrite", 64'(bus.inst_valid), 64'd0);
        fetch_ok("ar_refetch", 64'h1000);

        // random traffic
        do_reset();
        img.delete();
        for (int it = 0; it < 250; it++) begin
            gnt_wait = $urandom_range(0, 2);
            rsp_wait = $urandom_range(1, 3);
            base = ($urandom_range(0, 3) == 0) ?
                   64'hFFFF_FFFF_FFFF_FFC0 : 64'h1000;
            tick();
            p = base + 64'(2 * $urandom_range(0, 31));
            bus.pc = p;
            bus.flush = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                tick();
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                p = base + 64'(2 * $urandom_range(0, 31));
                bus.pc = p;
            end
            wait_valid(40, ok);
            chk("rnd_tmo", 64'(ok), 64'd1);
            if (ok) begin
                chk("rnd_inst", 64'(bus.inst), 64'(exp_inst(p)));
                chk("rnd_comp", 64'(bus.inst_comp), 64'(exp_comp(p)));
                held = bus.inst;
                tick();
                smp();
                chk("rnd_noreq", 64'(bus.mem_req), 64'd0);
                chk("rnd_hold", 64'(bus.inst), 64'(held));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
